// File: rtl/tdc_ctrl.sv
// tdc_ctrl: control FSM for a ring-oscillator TDC.
// The FSM enables the analog front end and waits SETTLE_CYC cycles for it to settle.
// It spends one cycle capturing a reference count, then on every clock it produces
// an (integer periods, fractional phase) sample.
// Optional thermometer-code bubble check: define TDC_CTRL_BUBBLE_CHK_EN.
module tdc_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int NUM_MEAS   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [6:0]  ripple_count,
  input  logic [15:0] phase,
  output logic        tdc_en,
  output logic [6:0]  tdc_int,
  output logic [4:0]  tdc_frac,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SETTLE, PRIME, RUN} state_t;

  localparam logic [7:0]  SETTLE_LOAD  = 8'(SETTLE_CYC);
  localparam logic [15:0] MEAS_LAST    = 16'(NUM_MEAS - 1);
  localparam bit          MEAS_BOUNDED = (NUM_MEAS != 0);

  state_t      state_q,  state_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] meas_q,   meas_d;
  logic [6:0]  prev_q,   prev_d;
  logic [6:0]  int_q,    int_d;
  logic [4:0]  frac_q,   frac_d;
  logic        en_q,     en_d;
  logic        valid_q,  valid_d;
  logic        busy_q,   busy_d;
`ifdef TDC_CTRL_BUBBLE_CHK_EN
  logic        err_q,    err_d;
`endif

  // Number of set bits in the thermometer phase word (0..16).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

`ifdef TDC_CTRL_BUBBLE_CHK_EN
  // Legal thermometer codes are 2^k-1: adding one must not overlap any set bit.
  function automatic logic is_thermo(input logic [15:0] v);
    logic [15:0] v_inc;
    v_inc = v + 16'd1;
    return ((v & v_inc) == 16'd0);
  endfunction
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    meas_d   = meas_q;
    prev_d   = prev_q;
    int_d    = int_q;
    frac_d   = frac_q;
    valid_d  = 1'b0;
`ifdef TDC_CTRL_BUBBLE_CHK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
`ifdef TDC_CTRL_BUBBLE_CHK_EN
          err_d    = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          settle_d = settle_q - 8'd1;
          if (settle_q <= 8'd1) state_d = PRIME;
        end
      end
      PRIME: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          prev_d  = ripple_count;
          meas_d  = 16'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          // 7-bit subtraction gives the modulo-128 wrap of the ripple counter.
          int_d   = ripple_count - prev_q;
          prev_d  = ripple_count;
          frac_d  = popcount16(phase);
          valid_d = 1'b1;
          meas_d  = meas_q + 16'd1;
`ifdef TDC_CTRL_BUBBLE_CHK_EN
          if (!is_thermo(phase)) err_d = 1'b1;
`endif
          if (MEAS_BOUNDED && (meas_q == MEAS_LAST)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    en_d   = (state_d != IDLE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= 8'd0;
      meas_q   <= 16'd0;
      prev_q   <= 7'd0;
      int_q    <= 7'd0;
      frac_q   <= 5'd0;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef TDC_CTRL_BUBBLE_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      meas_q   <= meas_d;
      prev_q   <= prev_d;
      int_q    <= int_d;
      frac_q   <= frac_d;
      en_q     <= en_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef TDC_CTRL_BUBBLE_CHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign tdc_en   = en_q;
  assign tdc_int  = int_q;
  assign tdc_frac = frac_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
`ifdef TDC_CTRL_BUBBLE_CHK_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_ctrl.sv
// tb_tdc_ctrl: two tdc_ctrl instances sharing stimulus; instance A is a bounded
// run (SETTLE_CYC=4, NUM_MEAS=3), instance B a continuous one (SETTLE_CYC=2).
// A timeline-based reference model predicts every output of both each cycle.
module tb_tdc_ctrl;
  localparam int S_A = 4, N_A = 3, S_B = 2, N_B = 0;
`ifdef TDC_CTRL_BUBBLE_CHK_EN
  localparam int BUB_ON = 1;
`else
  localparam int BUB_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, stop;
  logic [6:0]  rc;
  logic [15:0] ph;
  logic en_a, valid_a, busy_a, err_a, en_b, valid_b, busy_b, err_b;
  logic [6:0] int_a, int_b;
  logic [4:0] frac_a, frac_b;

  int n_tot = 0, n_bad = 0;
  int va_cnt = 0, vb_cnt = 0;
  bit auto_rc = 1'b0;
  int inc = 0;

  // reference model state, index 0 = A, 1 = B
  bit m_act[2], m_en[2], m_busy[2], m_valid[2], m_err[2];
  int m_t[2], m_n[2], m_prev[2], m_int[2], m_frac[2];

  tdc_ctrl #(.SETTLE_CYC(S_A), .NUM_MEAS(N_A)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ripple_count(rc), .phase(ph),
    .tdc_en(en_a), .tdc_int(int_a), .tdc_frac(frac_a), .valid(valid_a), .busy(busy_a), .err(err_a));

  tdc_ctrl #(.SETTLE_CYC(S_B), .NUM_MEAS(N_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ripple_count(rc), .phase(ph),
    .tdc_en(en_b), .tdc_int(int_b), .tdc_frac(frac_b), .valid(valid_b), .busy(busy_b), .err(err_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_bubble(input logic [15:0] v);
    for (int k = 0; k <= 16; k++)
      if (32'(v) == (1 << k) - 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_en[i] = 0; m_busy[i] = 0; m_valid[i] = 0; m_err[i] = 0;
      m_t[i] = 0; m_n[i] = 0; m_prev[i] = 0; m_int[i] = 0; m_frac[i] = 0;
    end
  endtask

  // Run timeline: accepted start at t=0, reference capture at t=S+1, samples from t=S+2.
  task automatic model_edge();
    int s, nm;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      s  = (i == 0) ? S_A : S_B;
      nm = (i == 0) ? N_A : N_B;
      m_valid[i] = 0;
      if (!m_act[i]) begin
        if (start && !stop) begin
          m_act[i] = 1; m_t[i] = 0; m_n[i] = 0; m_err[i] = 0;
          m_en[i] = 1; m_busy[i] = 1;
        end
      end else begin
        m_t[i]++;
        if (stop) begin
          m_act[i] = 0; m_en[i] = 0; m_busy[i] = 0;
        end else if (m_t[i] == s + 1) begin
          m_prev[i] = int'(rc);
        end else if (m_t[i] >= s + 2) begin
          m_valid[i] = 1;
          m_int[i]   = ((int'(rc) - m_prev[i]) % 128 + 128) % 128;
          m_prev[i]  = int'(rc);
          m_frac[i]  = $countones(ph);
          if (BUB_ON != 0 && is_bubble(ph)) m_err[i] = 1;
          m_n[i]++;
          if (nm != 0 && m_n[i] == nm) begin
            m_act[i] = 0; m_en[i] = 0; m_busy[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("a.en",    32'(en_a),    32'(m_en[0]));
    chk("a.busy",  32'(busy_a),  32'(m_busy[0]));
    chk("a.valid", 32'(valid_a), 32'(m_valid[0]));
    chk("a.int",   32'(int_a),   32'(m_int[0]));
    chk("a.frac",  32'(frac_a),  32'(m_frac[0]));
    chk("a.err",   32'(err_a),   32'(m_err[0]));
    chk("b.en",    32'(en_b),    32'(m_en[1]));
    chk("b.busy",  32'(busy_b),  32'(m_busy[1]));
    chk("b.valid", 32'(valid_b), 32'(m_valid[1]));
    chk("b.int",   32'(int_b),   32'(m_int[1]));
    chk("b.frac",  32'(frac_b),  32'(m_frac[1]));
    chk("b.err",   32'(err_b),   32'(m_err[1]));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (valid_a) va_cnt++;
    if (valid_b) vb_cnt++;
    if (auto_rc) rc = rc + 7'(inc);
  endtask

  task automatic stop_pulse();
    stop = 1'b1; cyc(); stop = 1'b0; cyc();
  endtask

  initial begin
    int first_k;
    int k;
    rst = 1'b1; start = 1'b0; stop = 1'b0; rc = 7'd0; ph = 16'h0000;
    model_reset();
    cyc(); cyc();
    chk("rst.busy", 32'(busy_a), 32'd0);
    chk("rst.en",   32'(en_b),   32'd0);
    rst = 1'b0;
    cyc();

    // basic run
    auto_rc = 1'b1; inc = 10; ph = 16'h00FF; va_cnt = 0; first_k = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (k = 2; k <= 20; k++) begin
      cyc();
      if (valid_a && first_k == 0) first_k = k;
      if (valid_a) begin
        chk("basic.int",  32'(int_a),  32'd10);
        chk("basic.frac", 32'(frac_a), 32'd8);
      end
    end
    chk("basic.lat",  32'(first_k), 32'd7);
    chk("basic.nval", 32'(va_cnt),  32'd3);
    chk("basic.busy", 32'(busy_a),  32'd0);
    chk("basic.en",   32'(en_a),    32'd0);
    stop_pulse();

    // wrap-around and constant count
    auto_rc = 1'b0; rc = 7'd0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    rc = 7'd120; cyc();
    rc = 7'd5;   cyc();
    chk("wrap.int", 32'(int_b), 32'd13);
    cyc();
    chk("const.int", 32'(int_b), 32'd0);
    stop_pulse();

    // abort after two valids
    auto_rc = 1'b1; inc = 3; vb_cnt = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 20 && vb_cnt < 2; i++) cyc();
    chk("abort.wait", 32'(vb_cnt), 32'd2);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("abort.busy",  32'(busy_b),  32'd0);
    chk("abort.en",    32'(en_b),    32'd0);
    chk("abort.valid", 32'(valid_b), 32'd0);
    for (int i = 0; i < 5; i++) cyc();
    chk("abort.noval", 32'(vb_cnt), 32'd2);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("ss.busy_a", 32'(busy_a), 32'd0);
    chk("ss.busy_b", 32'(busy_b), 32'd0);
    cyc();

    // asynchronous reset during SETTLE
    start = 1'b1; cyc(); start = 1'b0; cyc();
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    chk("arst.en",  32'(en_a),  32'd0);
    chk("arst.int", 32'(int_b), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("arst.idle", 32'(busy_a), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("arst.restart", 32'(busy_a), 32'd1);
    stop_pulse();

    // bubble check
    inc = 5; ph = 16'h00FF; vb_cnt = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 20 && vb_cnt == 0; i++) cyc();
    chk("bub.wait", 32'(vb_cnt), 32'd1);
    ph = 16'h00F7; cyc();
    chk("bub.valid", 32'(valid_b), 32'd1);
    chk("bub.frac",  32'(frac_b),  32'd7);
    chk("bub.err",   32'(err_b),   32'(BUB_ON));
    ph = 16'h000F; cyc();
    chk("bub.sticky", 32'(err_b), 32'(BUB_ON));
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("bub.idle", 32'(err_b), 32'(BUB_ON));
    start = 1'b1; cyc(); start = 1'b0;
    chk("bub.clear", 32'(err_b), 32'd0);
    stop_pulse();

    // start while busy
    inc = 10; ph = 16'h0003; va_cnt = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 20 && va_cnt == 0; i++) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("sbusy.nval", 32'(va_cnt), 32'd3);
    stop_pulse();

    // randomized traffic
    auto_rc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(7) == 0);
      stop  = ($urandom_range(23) == 0);
      rst   = ($urandom_range(99) == 0);
      rc    = 7'($urandom);
      if ($urandom_range(2) == 0) ph = 16'($urandom);
      else ph = 16'((1 << $urandom_range(16)) - 1);
      cyc();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/tdc_ctrl.md
TDC_CTRL -- requirements
Module: tdc_ctrl

Interface
REQ-001 The module SHALL have parameter SETTLE_CYC, default 4: clk cycles tdc_en is held high before sampling starts; legal range 1..255.
REQ-002 The module SHALL have parameter NUM_MEAS, default 0: number of measurements per run, 16-bit; 0 means continuous until stop.
REQ-003 The module SHALL have port clk, input, 1 bit: reference clock (32 MHz), rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: begin a measurement run; sampled on the rising edge.
REQ-006 The module SHALL have port stop, input, 1 bit: abort the run.
REQ-007 The module SHALL have port ripple_count, input, 7 bits: free-running oscillator ripple counter from the analog TDC.
REQ-008 The module SHALL have port phase, input, 16 bits: thermometer-coded oscillator phase from the analog TDC.
REQ-009 The module SHALL have port tdc_en, output, 1 bit: enable to the analog TDC.
REQ-010 The module SHALL have port tdc_int, output, 7 bits: integer oscillator periods elapsed since the previous sample.
REQ-011 The module SHALL have port tdc_frac, output, 5 bits: fractional phase, equal to the number of ones in phase (0..16).
REQ-012 The module SHALL have port valid, output, 1 bit: one-cycle strobe marking tdc_int/tdc_frac as new.
REQ-013 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The module SHALL have port err, output, 1 bit: sticky phase-bubble flag (see Configuration).

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SETTLE, PRIME and RUN; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 with stop=0 SHALL move to SETTLE on that edge, set tdc_en=1, and load the settle counter with SETTLE_CYC.
REQ-017 In SETTLE, the counter SHALL decrement each cycle; on reaching 0 the FSM SHALL go to PRIME after exactly SETTLE_CYC cycles in SETTLE.
REQ-018 PRIME SHALL last one cycle: capture ripple_count into prev_cnt, clear the measurement counter, go to RUN, and keep valid=0.
REQ-019 In RUN, every cycle SHALL register tdc_int=(ripple_count-prev_cnt) mod 128, prev_cnt=ripple_count, tdc_frac=popcount(phase), and valid=1, and SHALL increment the measurement counter.
REQ-020 The first valid SHALL go high in the cycle after the (SETTLE_CYC+3)-th rising edge counted from the edge that sampled start.
REQ-021 When NUM_MEAS!=0, the cycle that produces the NUM_MEAS-th valid SHALL be the last: the next state is IDLE, and tdc_en=0 and busy=0 from the following edge.
REQ-022 Counter wrap SHALL use modulo-128 subtraction (prev 120, current 5 -> tdc_int=13); equal values SHALL give 0.
REQ-023 stop=1 in any non-IDLE state SHALL force IDLE on that edge with tdc_en=0 and valid=0; stop SHALL have priority over start and over completion.
REQ-024 start while busy SHALL be ignored; start and stop together in IDLE SHALL leave the FSM in IDLE.
REQ-025 tdc_int and tdc_frac SHALL hold their last values outside RUN.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, tdc_en=0, valid=0, busy=0, err=0, tdc_int=0, tdc_frac=0, prev_cnt=0, and all internal counters to 0, regardless of clk.
REQ-027 Reset asserted mid-run SHALL abort the run with no further valid; after deassertion a new start SHALL be required.

Configuration
REQ-028 With TDC_CTRL_BUBBLE_CHK_EN defined, in RUN err SHALL be set when phase is not a legal thermometer code (ones not contiguous from bit 0; legal codes are 2^k-1 for k=0..16). err SHALL stay sticky until rst or an accepted start, and a bubble SHALL still produce valid with tdc_frac=popcount.
REQ-029 Without TDC_CTRL_BUBBLE_CHK_EN, err SHALL be tied 0 and no bubble-check logic SHALL be synthesised.

Verification
REQ-030 The bench SHALL check basic run: SETTLE_CYC=4, NUM_MEAS=3, ripple_count stepping +10 per cycle, phase=16'h00FF -> first valid 7 cycles after start, three valids each with tdc_int=10 and tdc_frac=8, then busy=0 and tdc_en=0.
REQ-031 The bench SHALL check wrap-around: prev 120 then 5 -> tdc_int=13; constant ripple_count -> tdc_int=0.
REQ-032 The bench SHALL check abort: NUM_MEAS=0 with stop pulsed after 2 valids -> IDLE next edge, no third valid, tdc_en=0; start+stop together in IDLE -> stays IDLE.
REQ-033 The bench SHALL check async reset: rst asserted between clock edges during SETTLE -> outputs go to reset values immediately, and start is needed to restart.
REQ-034 The bench SHALL check the bubble check (macro on): phase=16'h00F7 -> err=1, valid=1, tdc_frac=7, err still 1 after phase=16'h000F, cleared by the next start; macro off -> err stays 0.
REQ-035 The bench SHALL check start while busy: start pulsed during RUN -> no restart, measurement count unaffected.
